// File: rtl/sram_word_ctrl_pkg.sv
// Shared types and constants for the byte-wide external memory word sequencer.
package sram_word_ctrl_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/sram_word_ctrl_if.sv
// Core-side word request bus of sram_word_ctrl.
// SRAM_WORD_CTRL_BYTE_MASK_EN adds the be byte-enable field.
interface sram_word_ctrl_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
`ifdef SRAM_WORD_CTRL_BYTE_MASK_EN
    logic [3:0]  be;

    modport master (output req, we, addr, wdata, be, input rdata, busy, done);
    modport slave  (input req, we, addr, wdata, be, output rdata, busy, done);
`else
    modport master (output req, we, addr, wdata, input rdata, busy, done);
    modport slave  (input req, we, addr, wdata, output rdata, busy, done);
`endif

endinterface

// File: rtl/sram_word_ctrl.sv
// Splits one 32-bit word request into four little-endian byte accesses on an external SRAM.
// Optional SRAM_WORD_CTRL_BYTE_MASK_EN skips the write strobe for disabled bytes.
module sram_word_ctrl
    import sram_word_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 19,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    sram_word_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
);

    if (WAIT_CYCLES < 1) begin : g_wait_check
        $fatal(1, "sram_word_ctrl: WAIT_CYCLES must be at least 1");
    end

    localparam int CntW = $clog2(WAIT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BYTES_PER_WORD - 1);

    ctrl_state_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-3:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
`ifdef SRAM_WORD_CTRL_BYTE_MASK_EN
    logic [3:0]         be_q, be_d;
`endif

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;

    // Word alignment drops addr[1:0]; bits above ADDR_W have no pins.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[31:ADDR_W], bus.addr[1:0]};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SRAM_WORD_CTRL_BYTE_MASK_EN
        be_d    = be_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr[ADDR_W-1:2];
                    we_d    = bus.we;
                    wdata_d = bus.wdata;
                    idx_d   = '0;
                    state_d = SETUP;
                    if (!bus.we) begin
                        rdata_d = '0;
                    end
`ifdef SRAM_WORD_CTRL_BYTE_MASK_EN
                    be_d = bus.be;
                    if (bus.we && bus.be == 4'b0000) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            SETUP: begin
                cnt_d   = CntW'(WAIT_CYCLES);
                state_d = ACCESS;
`ifdef SRAM_WORD_CTRL_BYTE_MASK_EN
                // A masked write byte gets its address setup cycle but never a strobe.
                if (we_q && !be_q[idx_q]) begin
                    if (idx_q == LastIdx) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SETUP;
                    end
                end
`endif
            end
            ACCESS: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    if (!we_q) begin
                        rdata_d[{idx_q, 3'b000} +: 8] = mem_rdata;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SETUP;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pin outputs are decoded from the next state and registered, so they never glitch.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        ce_n_d      = !(state_d == SETUP || state_d == ACCESS);
        oe_n_d      = !(state_d == ACCESS && !we_d);
        we_n_d      = !(state_d == ACCESS && we_d);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == SETUP) begin
            mem_addr_d  = {addr_d, idx_d};
            mem_wdata_d = wdata_d[{idx_d, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
`ifdef SRAM_WORD_CTRL_BYTE_MASK_EN
            be_q        <= '0;
`endif
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
`ifdef SRAM_WORD_CTRL_BYTE_MASK_EN
            be_q        <= be_d;
`endif
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ce_n  = ce_n_q;
    assign mem_oe_n  = oe_n_q;
    assign mem_we_n  = we_n_q;

endmodule
